// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: buffered serial transmitter for the vga_serial_display path.
//   Frames each byte as 8N1 / 8E1 / 8O1 with one or two stop bits and drives the UART TX pin.
//   A one-byte holding register accepts the next byte while the current frame shifts out,
//   so queued frames leave back to back with no idle gap between the stop bit and the next start bit.
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   tx_data    byte to send, captured on an accepting edge of tx_start
//   tx_start   request strobe; a held level counts as one request per accepting edge
//   tx         serial line, idle high, straight from a flop
//   busy       high while a frame is on the line
//   ready      high while the holding register is empty
//   tx_done    one-cycle pulse after the final stop bit of each frame
//   overrun    one-cycle pulse when a request arrives with nowhere to put it (byte dropped)
module uart_tx_buffered #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int PARITY    = 0,  // 0 none, 1 odd, 2 even
  parameter int STOP_BITS = 1   // 1 or 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx,
  output logic       busy,
  output logic       ready,
  output logic       tx_done,
  output logic       overrun
);

  // Rounded integer divider; there is no fractional correction, so the line
  // rate error is whatever this rounding leaves.
  localparam int BAUD_DIV = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [2:0]       DATA_LAST = 3'd7;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;     // data bit index in DATA, stop bit index in STOP
  logic [7:0]       shift;
  logic             par_bit;
  logic [7:0]       hold_byte;
  logic             hold_full;

  logic bit_end;
  logic frame_end;
  logic load;
  logic accept;
  logic hold_par;

  assign bit_end   = (baud_cnt == CNT_LAST);
  assign frame_end = (state == S_STOP) && bit_end && (bit_idx == STOP_LAST);

  // The shifter takes the held byte either from idle or on the very edge the
  // previous frame ends, which is what removes the inter-frame gap.
  assign load = hold_full && ((state == S_IDLE) || frame_end);

  // On a load edge the holding register is being emptied, so a request on
  // that same edge is accepted rather than flagged as an overrun.
  assign accept = tx_start && (!hold_full || load);

  // Parity is computed from the held byte at load time so it is ready long
  // before the parity slot, independent of how far the shifter has moved.
  assign hold_par = (PARITY == 2) ? (^hold_byte) : ~(^hold_byte);

  assign ready = !hold_full;
  assign busy  = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      par_bit   <= 1'b0;
      hold_byte <= '0;
      hold_full <= 1'b0;
      tx        <= 1'b1;
      tx_done   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      tx_done <= frame_end;
      overrun <= tx_start && hold_full && !load;

      // Holding register
      if (accept) begin
        hold_byte <= tx_data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      if (load) begin
        shift    <= hold_byte;
        par_bit  <= hold_par;
        state    <= S_START;
        tx       <= 1'b0;
        baud_cnt <= '0;
        bit_idx  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
          end

          S_START: begin
            if (bit_end) begin
              baud_cnt <= '0;
              bit_idx  <= '0;
              state    <= S_DATA;
              tx       <= shift[0];
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end

          S_DATA: begin
            if (bit_end) begin
              baud_cnt <= '0;
              if (bit_idx == DATA_LAST) begin
                bit_idx <= '0;
                if (PARITY != 0) begin
                  state <= S_PARITY;
                  tx    <= par_bit;
                end else begin
                  state <= S_STOP;
                  tx    <= 1'b1;
                end
              end else begin
                // shift[1] is the bit that becomes shift[0] after this edge
                bit_idx <= bit_idx + 1'b1;
                shift   <= {1'b0, shift[7:1]};
                tx      <= shift[1];
              end
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end

          S_PARITY: begin
            if (bit_end) begin
              baud_cnt <= '0;
              bit_idx  <= '0;
              state    <= S_STOP;
              tx       <= 1'b1;
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end

          S_STOP: begin
            tx <= 1'b1;
            if (bit_end) begin
              baud_cnt <= '0;
              if (bit_idx == STOP_LAST) begin
                // holding full at this point is handled by the load branch
                bit_idx <= '0;
                state   <= S_IDLE;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end

          default: begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: three instances share one stimulus stream
// (8N1, 8E2, 8O1 at BAUD_DIV=4). A line-level model queues the expected tx
// level for every future clock of each accepted frame and is compared with
// all outputs every cycle; directed steps add hand-computed literal checks.
module tb_uart_tx_buffered;

  localparam int BD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [2:0] tx_o, busy_o, ready_o, done_o, ovr_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_buffered #(.CLK_FREQ(40), .BAUD_RATE(10), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
    .tx(tx_o[0]), .busy(busy_o[0]), .ready(ready_o[0]), .tx_done(done_o[0]), .overrun(ovr_o[0]));
  uart_tx_buffered #(.CLK_FREQ(40), .BAUD_RATE(10), .PARITY(2), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
    .tx(tx_o[1]), .busy(busy_o[1]), .ready(ready_o[1]), .tx_done(done_o[1]), .overrun(ovr_o[1]));
  uart_tx_buffered #(.CLK_FREQ(40), .BAUD_RATE(10), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
    .tx(tx_o[2]), .busy(busy_o[2]), .ready(ready_o[2]), .tx_done(done_o[2]), .overrun(ovr_o[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int cfg_par(int i);
    return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
  endfunction
  function automatic int cfg_stops(int i);
    return (i == 1) ? 2 : 1;
  endfunction

  bit         wave[3][$];   // expected line level for each upcoming clock
  bit         held[3];
  logic [7:0] held_byte[3];
  logic [2:0] e_tx, e_busy, e_ready, e_done, e_ovr;
  bit         started = 1'b0;
  bit         fin, hb, ld;

  task automatic push_level(int i, bit lvl);
    for (int k = 0; k < BD; k++) wave[i].push_back(lvl);
  endtask

  task automatic push_frame(int i, logic [7:0] d);
    push_level(i, 1'b0);
    for (int k = 0; k < 8; k++) push_level(i, d[k]);
    if (cfg_par(i) == 2) push_level(i, ^d);
    if (cfg_par(i) == 1) push_level(i, ~(^d));
    for (int s = 0; s < cfg_stops(i); s++) push_level(i, 1'b1);
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        wave[i].delete();
        held[i]  = 1'b0;
        e_done[i] = 1'b0;
        e_ovr[i]  = 1'b0;
      end else begin
        fin = 1'b0;
        if (wave[i].size() != 0) begin
          void'(wave[i].pop_front());
          if (wave[i].size() == 0) fin = 1'b1;
        end
        hb = held[i];
        ld = (wave[i].size() == 0) && hb;
        if (ld) begin
          push_frame(i, held_byte[i]);
          held[i] = 1'b0;
        end
        e_ovr[i]  = tx_start && hb && !ld;
        e_done[i] = fin;
        if (tx_start && (!hb || ld)) begin
          held[i]      = 1'b1;
          held_byte[i] = tx_data;
        end
      end
      e_tx[i]    = (wave[i].size() != 0) ? wave[i][0] : 1'b1;
      e_busy[i]  = (wave[i].size() != 0);
      e_ready[i] = !held[i];
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("m%0d_tx", i),      tx_o[i],    e_tx[i]);
        chk($sformatf("m%0d_busy", i),    busy_o[i],  e_busy[i]);
        chk($sformatf("m%0d_ready", i),   ready_o[i], e_ready[i]);
        chk($sformatf("m%0d_tx_done", i), done_o[i],  e_done[i]);
        chk($sformatf("m%0d_overrun", i), ovr_o[i],   e_ovr[i]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Called at a negedge; the following posedge is the strobe edge E0 and the
  // task returns on the negedge after it.
  task automatic send(input logic [7:0] d);
    tx_start = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy_o != 3'b000 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, busy_o, 3'b000);
    repeat (2) @(negedge clk);
  endtask

  logic [9:0] seq55;
  int first_d, second_d, n, pulses;

  initial begin
    rst      = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    seq55    = 10'b1010101010;   // index = bit slot: start, d0..d7, stop

    // T1 reset
    repeat (2) @(negedge clk);
    chk("t1_tx",      tx_o,    3'b111);
    chk("t1_busy",    busy_o,  3'b000);
    chk("t1_ready",   ready_o, 3'b111);
    chk("t1_tx_done", done_o,  3'b000);
    chk("t1_overrun", ovr_o,   3'b000);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // T2 0x55 on 8N1: tx still high after E0, low after E1
    send(8'h55);
    chk("t2_after_e0", tx_o[0], 1'b1);
    chk("t2_ready_e0", ready_o[0], 1'b0);
    @(negedge clk);                       // offset 0 = after E1
    chk("t2_fall", tx_o[0], 1'b0);
    chk("t2_busy", busy_o[0], 1'b1);
    repeat (2) @(negedge clk);
    for (int b = 0; b < 10; b++) begin
      chk($sformatf("t2_slot%0d", b), tx_o[0], seq55[b]);
      if (b < 9) repeat (4) @(negedge clk);
    end
    @(negedge clk);                       // offset 39
    chk("t2_done_early", done_o[0], 1'b0);
    @(negedge clk);                       // offset 40
    chk("t2_done", done_o[0], 1'b1);
    @(negedge clk);
    chk("t2_done_width", done_o[0], 1'b0);
    wait_idle("t2_idle");

    // T3/T4: 0xA5, 0x3C strobed on the load edge, 0xFF overruns
    send(8'hA5);
    send(8'h3C);
    chk("t3_no_ovr_on_load", ovr_o[0], 1'b0);
    chk("t3_ready_low", ready_o[0], 1'b0);
    send(8'hFF);
    chk("t4_overrun", ovr_o[0], 1'b1);
    chk("t4_ready_low", ready_o[0], 1'b0);
    @(negedge clk);
    chk("t4_overrun_width", ovr_o[0], 1'b0);
    first_d = -1; second_d = -1; n = 0;
    while (second_d < 0 && n < 400) begin
      @(negedge clk);
      n++;
      if (done_o[0]) begin
        if (first_d < 0) begin
          first_d = n;
          chk("t3_zero_gap", tx_o[0], 1'b0);
          chk("t3_ready_after_load", ready_o[0], 1'b1);
        end else begin
          second_d = n;
          chk("t3_idle_after", tx_o[0], 1'b1);
        end
      end
    end
    chk("t3_second_done_seen", second_d >= 0, 1'b1);
    chk("t3_done_spacing", second_d - first_d, 40);
    wait_idle("t3_idle");

    // T5 0x07: even parity bit 1 (u1), odd parity bit 0 (u2)
    send(8'h07);
    @(negedge clk);                       // offset 0
    repeat (38) @(negedge clk);           // offset 38, parity slot 36..39
    chk("t5_even_parity", tx_o[1], 1'b1);
    chk("t5_odd_parity",  tx_o[2], 1'b0);
    repeat (6) @(negedge clk);            // offset 44
    chk("t5_odd_done", done_o[2], 1'b1);
    chk("t5_even_stop_a", tx_o[1], 1'b1);
    repeat (3) @(negedge clk);            // offset 47
    chk("t5_even_stop_b", tx_o[1], 1'b1);
    chk("t5_even_done_early", done_o[1], 1'b0);
    @(negedge clk);                       // offset 48
    chk("t5_even_done", done_o[1], 1'b1);
    wait_idle("t5_idle");

    // T6 reset during bit 3 of 0x81, then 0x42
    send(8'h81);
    @(negedge clk);                       // offset 0
    repeat (17) @(negedge clk);           // offset 17, inside bit 3 (16..19)
    rst = 1'b1;
    @(negedge clk);
    chk("t6_tx",    tx_o,    3'b111);
    chk("t6_busy",  busy_o,  3'b000);
    chk("t6_ready", ready_o, 3'b111);
    rst = 1'b0;
    pulses = 0;
    repeat (60) begin
      @(negedge clk);
      if (done_o != 3'b000) pulses++;
    end
    chk("t6_no_done", pulses, 0);
    send(8'h42);
    n = 0;
    while (!done_o[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t6_new_frame_done", done_o[0], 1'b1);
    wait_idle("t6_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
